// File: rtl/instruction_encoder_if.sv
// Field-bundle input and encoded-word output channel for instruction_encoder.
// The slave side is the encoder; the master side is the loader that feeds it.
interface instruction_encoder_if #(
  parameter int ERR_CNT_W = 8
);
  logic                 in_valid;
  logic                 in_ready;
  logic [2:0]           format_sel;
  logic [6:0]           opcode;
  logic [4:0]           rd;
  logic [4:0]           rs1;
  logic [4:0]           rs2;
  logic [2:0]           funct3;
  logic [6:0]           funct7;
  logic [31:0]          immediate;
  logic                 addr_load;
  logic [31:0]          addr_value;
  logic                 out_valid;
  logic                 out_ready;
  logic [31:0]          out_instruction;
  logic [31:0]          out_address;
  logic                 out_range_error;
  logic [ERR_CNT_W-1:0] error_count;

  modport master (
    output in_valid, format_sel, opcode, rd, rs1, rs2, funct3, funct7,
           immediate, addr_load, addr_value, out_ready,
    input  in_ready, out_valid, out_instruction, out_address,
           out_range_error, error_count
  );

  modport slave (
    input  in_valid, format_sel, opcode, rd, rs1, rs2, funct3, funct7,
           immediate, addr_load, addr_value, out_ready,
    output in_ready, out_valid, out_instruction, out_address,
           out_range_error, error_count
  );
endinterface

// File: rtl/instruction_encoder.sv
// Packs RV32I fields and a full immediate into an instruction word, streaming
// it with a running word address through a two-stage valid/ready pipeline.
module instruction_encoder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          ERR_CNT_W = 8
) (
  input  logic clk,
  input  logic rst,
  instruction_encoder_if.slave bus
);

  typedef struct packed {
    logic [2:0]  fmt;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
  } req_t;

  req_t                 r_s1;
  logic [1:0]           r_vld_pipe;   // [0] = S1 occupied, [1] = S2 occupied
  logic [31:0]          r_instr;
  logic                 r_err;
  logic [31:0]          r_addr;
  logic [ERR_CNT_W-1:0] r_err_cnt;

  logic        w_s2_adv;
  logic        w_s1_adv;
  logic        w_out_xfer;
  logic [31:0] w_word;
  logic        w_err;
  logic [31:0] w_imm;

  assign w_s2_adv   = !r_vld_pipe[1] || bus.out_ready;
  assign w_s1_adv   = !r_vld_pipe[0] || w_s2_adv;
  assign w_out_xfer = r_vld_pipe[1] && bus.out_ready;
  assign w_imm      = r_s1.imm;

  assign bus.in_ready        = w_s1_adv;
  assign bus.out_valid       = r_vld_pipe[1];
  assign bus.out_instruction = r_instr;
  assign bus.out_range_error = r_err;
  assign bus.out_address     = r_addr;
  assign bus.error_count     = r_err_cnt;

  // A field is in range when every bit above its top is a sign copy.
  always_comb begin
    w_word = 32'h0000_0000;
    w_err  = 1'b0;
    case (r_s1.fmt)
      3'd0: w_word = {r_s1.funct7, r_s1.rs2, r_s1.rs1, r_s1.funct3, r_s1.rd, r_s1.opcode};
      3'd1: begin
        w_word = {w_imm[11:0], r_s1.rs1, r_s1.funct3, r_s1.rd, r_s1.opcode};
        w_err  = !((&w_imm[31:11]) || !(|w_imm[31:11]));
      end
      3'd2: begin
        w_word = {w_imm[11:5], r_s1.rs2, r_s1.rs1, r_s1.funct3, w_imm[4:0], r_s1.opcode};
        w_err  = !((&w_imm[31:11]) || !(|w_imm[31:11]));
      end
      3'd3: begin
        w_word = {w_imm[12], w_imm[10:5], r_s1.rs2, r_s1.rs1, r_s1.funct3,
                  w_imm[4:1], w_imm[11], r_s1.opcode};
        w_err  = !((&w_imm[31:12]) || !(|w_imm[31:12])) || w_imm[0];
      end
      3'd4: begin
        w_word = {w_imm[31:12], r_s1.rd, r_s1.opcode};
        w_err  = |w_imm[11:0];
      end
      3'd5: begin
        w_word = {w_imm[20], w_imm[10:1], w_imm[11], w_imm[19:12], r_s1.rd, r_s1.opcode};
        w_err  = !((&w_imm[31:20]) || !(|w_imm[31:20])) || w_imm[0];
      end
      default: w_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld_pipe <= 2'b00;
      r_s1       <= '0;
      r_instr    <= 32'h0000_0000;
      r_err      <= 1'b0;
    end else begin
      if (w_s1_adv) begin
        r_vld_pipe[0] <= bus.in_valid;
        if (bus.in_valid)
          r_s1 <= '{fmt: bus.format_sel, opcode: bus.opcode, rd: bus.rd,
                    rs1: bus.rs1, rs2: bus.rs2, funct3: bus.funct3,
                    funct7: bus.funct7, imm: bus.immediate};
      end
      if (w_s2_adv) begin
        r_vld_pipe[1] <= r_vld_pipe[0];
        if (r_vld_pipe[0]) begin
          r_instr <= w_word;
          r_err   <= w_err;
        end
      end
    end
  end

  // A load wins over the increment; the word leaving this cycle already
  // carried the old address.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr    <= BASE_ADDR;
      r_err_cnt <= '0;
    end else begin
      if (bus.addr_load)
        r_addr <= bus.addr_value;
      else if (w_out_xfer)
        r_addr <= r_addr + 32'd4;
      if (w_out_xfer && r_err && !(&r_err_cnt))
        r_err_cnt <= r_err_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_instruction_encoder.sv
// Directed bench for instruction_encoder with hand-computed expected words.
module tb_instruction_encoder;
  logic clk;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  instruction_encoder_if #(.ERR_CNT_W(8)) bus ();

  instruction_encoder #(.BASE_ADDR(32'h0000_0000), .ERR_CNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] f, input logic [6:0] op, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                       input logic [6:0] f7, input logic [31:0] imm);
    bus.format_sel = f;
    bus.opcode     = op;
    bus.rd         = rd;
    bus.rs1        = rs1;
    bus.rs2        = rs2;
    bus.funct3     = f3;
    bus.funct7     = f7;
    bus.immediate  = imm;
    bus.in_valid   = 1'b1;
  endtask

  task automatic chk_out(input string tag, input logic [31:0] w, input logic [31:0] a,
                         input logic e);
    chk({tag, "_vld"}, {31'b0, bus.out_valid}, 32'd1);
    chk({tag, "_word"}, bus.out_instruction, w);
    chk({tag, "_addr"}, bus.out_address, a);
    chk({tag, "_err"}, {31'b0, bus.out_range_error}, {31'b0, e});
  endtask

  logic [31:0] exp_w [4];
  logic [31:0] exp_a [4];

  initial begin
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.format_sel = 3'd0; bus.opcode = 7'h0;
    bus.rd = 5'd0; bus.rs1 = 5'd0; bus.rs2 = 5'd0; bus.funct3 = 3'd0;
    bus.funct7 = 7'h0; bus.immediate = 32'h0; bus.addr_load = 1'b0;
    bus.addr_value = 32'h0; bus.out_ready = 1'b1;
    repeat (2) step();

    chk("rst_vld", {31'b0, bus.out_valid}, 32'd0);
    chk("rst_word", bus.out_instruction, 32'h0);
    chk("rst_err", {31'b0, bus.out_range_error}, 32'd0);
    chk("rst_cnt", {24'b0, bus.error_count}, 32'd0);
    chk("rst_addr", bus.out_address, 32'h0);
    chk("rst_rdy", {31'b0, bus.in_ready}, 32'd1);
    rst = 1'b0;
    step();

    // I-type, two-cycle latency
    drive(3'd1, 7'h13, 5'd1, 5'd2, 5'd0, 3'd0, 7'h0, 32'hFFFF_FFFF);
    step();
    bus.in_valid = 1'b0;
    chk("lat_vld0", {31'b0, bus.out_valid}, 32'd0);
    step();
    chk_out("i", 32'hFFF1_0093, 32'h0, 1'b0);

    // back-to-back S, SB, U, UJ
    exp_w = '{32'h0051_2423, 32'hFE20_8EE3, 32'h1234_52B7, 32'h0010_00EF};
    exp_a = '{32'd4, 32'd8, 32'd12, 32'd16};
    for (int k = 0; k < 5; k++) begin
      case (k)
        0: drive(3'd2, 7'h23, 5'd0, 5'd2, 5'd5, 3'd2, 7'h0, 32'd8);
        1: drive(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'h0, 32'hFFFF_FFFC);
        2: drive(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'h0, 32'h1234_5000);
        3: drive(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'h0, 32'h0000_0800);
        default: bus.in_valid = 1'b0;
      endcase
      step();
      if (k >= 1) chk_out($sformatf("b2b%0d", k - 1), exp_w[k-1], exp_a[k-1], 1'b0);
    end

    // range errors and counter
    exp_w = '{32'h8000_0013, 32'h0000_0163, 32'h0000_0000, 32'h0};
    exp_a = '{32'd20, 32'd24, 32'd28, 32'd0};
    for (int k = 0; k < 4; k++) begin
      case (k)
        0: drive(3'd1, 7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 7'h0, 32'h0000_0800);
        1: drive(3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'h0, 32'd3);
        2: drive(3'd7, 7'h13, 5'd1, 5'd2, 5'd3, 3'd0, 7'h0, 32'h0);
        default: bus.in_valid = 1'b0;
      endcase
      step();
      if (k >= 1) begin
        chk_out($sformatf("err%0d", k - 1), exp_w[k-1], exp_a[k-1], 1'b1);
        chk($sformatf("err%0d_cnt", k - 1), {24'b0, bus.error_count}, k - 1);
      end
    end
    step();
    chk("err_cnt3", {24'b0, bus.error_count}, 32'd3);
    chk("err_idle", {31'b0, bus.out_valid}, 32'd0);

    // backpressure: two accepts then stall
    bus.out_ready = 1'b0;
    drive(3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h00, 32'h0);
    chk("bp_rdy0", {31'b0, bus.in_ready}, 32'd1);
    step();
    chk("bp_rdy1", {31'b0, bus.in_ready}, 32'd1);
    drive(3'd0, 7'h33, 5'd4, 5'd5, 5'd6, 3'd0, 7'h20, 32'h0);
    step();
    drive(3'd1, 7'h13, 5'd7, 5'd0, 5'd0, 3'd0, 7'h00, 32'd5);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("bp_stall%0d_rdy", k), {31'b0, bus.in_ready}, 32'd0);
      chk_out($sformatf("bp_hold%0d", k), 32'h0020_81B3, 32'd32, 1'b0);
      if (k < 2) step();
    end
    bus.out_ready = 1'b1;
    #1;
    chk("bp_release_rdy", {31'b0, bus.in_ready}, 32'd1);
    step();
    bus.in_valid = 1'b0;
    chk_out("bp_w1", 32'h4062_8233, 32'd36, 1'b0);
    step();
    chk_out("bp_w2", 32'h0050_0393, 32'd40, 1'b0);
    step();
    chk("bp_drained", {31'b0, bus.out_valid}, 32'd0);

    // address load and wrap
    bus.addr_load = 1'b1; bus.addr_value = 32'hFFFF_FFFC;
    step();
    bus.addr_load = 1'b0;
    drive(3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h00, 32'h0);
    step();
    drive(3'd0, 7'h33, 5'd4, 5'd5, 5'd6, 3'd0, 7'h20, 32'h0);
    step();
    bus.in_valid = 1'b0;
    chk_out("wrap0", 32'h0020_81B3, 32'hFFFF_FFFC, 1'b0);
    step();
    chk_out("wrap1", 32'h4062_8233, 32'h0, 1'b0);
    step();

    // load coincident with a transfer
    drive(3'd1, 7'h13, 5'd7, 5'd0, 5'd0, 3'd0, 7'h00, 32'd5);
    step();
    drive(3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h00, 32'h0);
    step();
    bus.in_valid = 1'b0;
    chk_out("ldx_old", 32'h0050_0393, 32'd4, 1'b0);
    bus.addr_load = 1'b1; bus.addr_value = 32'h0000_0100;
    step();
    bus.addr_load = 1'b0;
    chk_out("ldx_new", 32'h0020_81B3, 32'h0000_0100, 1'b0);
    step();

    // reset mid-stream with two words in flight
    bus.out_ready = 1'b0;
    drive(3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h00, 32'h0);
    step();
    drive(3'd0, 7'h33, 5'd4, 5'd5, 5'd6, 3'd0, 7'h20, 32'h0);
    step();
    bus.in_valid = 1'b0;
    chk_out("pre_rst", 32'h0020_81B3, 32'h0000_0104, 1'b0);
    chk("pre_rst_cnt", {24'b0, bus.error_count}, 32'd3);
    rst = 1'b1;
    #1;
    chk("mid_rst_vld", {31'b0, bus.out_valid}, 32'd0);
    chk("mid_rst_addr", bus.out_address, 32'h0);
    chk("mid_rst_cnt", {24'b0, bus.error_count}, 32'd0);
    chk("mid_rst_word", bus.out_instruction, 32'h0);
    step();
    rst = 1'b0;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("post_rst_vld%0d", k), {31'b0, bus.out_valid}, 32'd0);
    end
    chk("post_rst_addr", bus.out_address, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/instruction_encoder.md
Name: instruction_encoder

Overview:
- Inverse of the CPU's immediate generator: packs opcode, register fields, funct fields and a full 32-bit immediate into an RV32I instruction word in R/I/S/SB/U/UJ format.
- Sits in the program-load path ahead of instruction memory. Streams encoded words with consecutive word addresses for the memory write port, under valid/ready backpressure.
- Range-checks each immediate against its format and counts violations.

Parameters:
- BASE_ADDR, 32'h0000_0000, address of the first emitted word after reset.
- ERR_CNT_W, 8, width of the saturating error counter.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  input field bundle valid.
- in_ready  output  1  encoder can accept the bundle this cycle.
- format_sel  input  3  0=R, 1=I, 2=S, 3=SB, 4=U, 5=UJ; 6 and 7 are illegal.
- opcode  input  7  placed verbatim in bits [6:0].
- rd, rs1, rs2  input  5 each  register indices.
- funct3  input  3  function field.
- funct7  input  7  function field, used by R only.
- immediate  input  32  full signed immediate value; for U, the full value, of which bits [31:12] are used.
- addr_load  input  1  load the address counter.
- addr_value  input  32  value loaded into the address counter.
- out_valid  output  1  encoded word valid.
- out_ready  input  1  downstream accepts the word.
- out_instruction  output  32  encoded word.
- out_address  output  32  write address for out_instruction.
- out_range_error  output  1  immediate of this word failed its range check.
- error_count  output  ERR_CNT_W  saturating count of range errors emitted.

Behaviour:
- Reset (asynchronous): out_valid=0, out_instruction=0, out_range_error=0, error_count=0, address counter=BASE_ADDR, both pipeline stages empty. After reset, in_ready=1.
- Two-stage pipeline:
  - S1 registers the accepted bundle.
  - S2 registers the packed word and the error flag.
  - Latency is 2 cycles from the input handshake to out_valid. Throughput is 1 word per cycle when out_ready=1.
- Handshakes:
  - Input transfer occurs when in_valid&&in_ready. Output transfer occurs when out_valid&&out_ready.
  - A stage advances when it is empty or the next stage advances.
  - in_ready = !s1_valid || s2_advance. It is combinational from out_ready; there is no path from in_valid to in_ready.
  - While out_valid=1 and out_ready=0, out_instruction, out_address and out_range_error hold stable.
- Packing (bits [6:0]=opcode in every format):
  - R: funct7|rs2|rs1|funct3|rd.
  - I: imm[11:0]|rs1|funct3|rd.
  - S: imm[11:5]|rs2|rs1|funct3|imm[4:0].
  - SB: imm[12]|imm[10:5]|rs2|rs1|funct3|imm[4:1]|imm[11].
  - U: imm[31:12]|rd.
  - UJ: imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd.
- Range check, computed in S2:
  - I and S: immediate[31:11] must be all equal.
  - SB: immediate[31:12] must be all equal and immediate[0]=0.
  - UJ: immediate[31:20] must be all equal and immediate[0]=0.
  - U: immediate[11:0]=0.
  - R: never an error.
  - format_sel 6 or 7: always an error, and out_instruction=32'h0000_0000.
  - An errored word is still emitted, with the truncated fields, and out_range_error=1.
- error_count increments by 1 on each output transfer with out_range_error=1 and saturates at all-ones.
- Address counter:
  - out_address equals the counter value while the word is presented.
  - The counter increments by 4 on each output transfer and wraps 32'hFFFF_FFFC -> 0.
  - If addr_load=1, counter <= addr_value. The load takes priority over the increment.
  - On a simultaneous load and transfer, the transferring word keeps the old address and the next word uses addr_value.
- Reset asserted mid-stream flushes both stages immediately. Words in flight are dropped and no transfer occurs.

Test Plan:
- I, opcode 0x13, rd=1, rs1=2, funct3=0, imm=32'hFFFF_FFFF -> out_instruction 32'hFFF1_0093, out_address 0, error 0, out_valid 2 cycles after the input handshake.
- Back-to-back S, then SB, then U, then UJ:
  - S, opcode 0x23, rs1=2, rs2=5, funct3=2, imm=8 -> 32'h0051_2423.
  - SB, opcode 0x63, rs1=1, rs2=2, imm=-4 -> 32'hFE20_8EE3.
  - U, opcode 0x37, rd=5, imm=32'h1234_5000 -> 32'h1234_52B7.
  - UJ, opcode 0x6F, rd=1, imm=32'h800 -> 32'h0010_00EF.
  - Addresses 4, 8, 12, 16; one word per cycle.
- I with imm=32'h800 -> word carries imm field 12'h800, out_range_error=1, error_count=1. SB with imm=3 -> error, error_count=2. Format 7 -> word 0, error_count=3.
- out_ready held 0 while 3 inputs are offered -> in_ready drops after 2 accepts, outputs stay stable. Release out_ready -> all 3 words drain in order at consecutive addresses.
- addr_load with addr_value=32'hFFFF_FFFC, then 2 words -> addresses FFFF_FFFC then 0. Load coincident with a transfer -> transferring word keeps its old address.
- rst pulsed with 2 words in flight -> out_valid=0 immediately, address returns to BASE_ADDR, error_count=0.
